roi_scan_ctrl: RTL and testbench

Serial scan controller that feeds a ROI under test from a narrow pin interface and reads its results back. It shifts `DIN_N` stimulus bits into a staging register and loads them in parallel onto the ROI input bus. It then waits a fixed settle interval, captures the `DOUT_N`-bit ROI output bus, and shifts the result out serially. It sits between the top-level pins and the `roi` instance and replaces the free-running strobe-driven shift logic with a sequenced, handshaked run.

---
 rtl/roi_scan_ctrl_if.sv | 32 +++
 rtl/roi_scan_ctrl.sv | 121 ++++++++++++
 tb/tb_roi_scan_ctrl.sv | 244 ++++++++++++++++++++++++
 3 files changed

// File: rtl/roi_scan_ctrl_if.sv
// ----------------------------------------------------------------------------
// roi_scan_ctrl_if : pin-side handshake and ROI parallel buses of the scan ctrl
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

interface roi_scan_ctrl_if #(
   parameter int DIN_N  = 256,
   parameter int DOUT_N = 256
);
   logic              start_i;
   logic              di_i;
   logic              di_valid_i;
   logic [DIN_N-1:0]  din_o;
   logic [DOUT_N-1:0] dout_i;
   logic              do_o;
   logic              do_valid_o;
   logic              busy_o;
   logic              done_o;

   modport master (
      output start_i, di_i, di_valid_i, dout_i,
      input  din_o, do_o, do_valid_o, busy_o, done_o
   );

   modport slave (
      input  start_i, di_i, di_valid_i, dout_i,
      output din_o, do_o, do_valid_o, busy_o, done_o
   );
endinterface

`default_nettype wire

// File: rtl/roi_scan_ctrl.sv
// ----------------------------------------------------------------------------
// roi_scan_ctrl : serial scan-in, parallel load, settle, capture, serial scan-out
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module roi_scan_ctrl #(
   parameter int DIN_N    = 256,
   parameter int DOUT_N   = 256,
   parameter int SETTLE_N = 2
) (
   input  wire logic        clk,
   input  wire logic        rst_n,
   roi_scan_ctrl_if.slave   bus
);

   localparam int C_MAX_IO = (DIN_N > DOUT_N) ? DIN_N : DOUT_N;
   localparam int C_MAX_N  = (C_MAX_IO > SETTLE_N) ? C_MAX_IO : SETTLE_N;
   localparam int CNT_W    = $clog2(C_MAX_N + 1);

   typedef enum logic [2:0] {
      S_IDLE      = 3'd0,
      S_SHIFT_IN  = 3'd1,
      S_LOAD      = 3'd2,
      S_SETTLE    = 3'd3,
      S_CAPTURE   = 3'd4,
      S_SHIFT_OUT = 3'd5,
      S_DONE      = 3'd6
   } state_t;

   state_t            state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [DIN_N-1:0]  din_shr_q, din_shr_d;
   logic [DIN_N-1:0]  din_q, din_d;
   logic [DOUT_N-1:0] dout_shr_q, dout_shr_d;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q    <= S_IDLE;
         cnt_q      <= '0;
         din_shr_q  <= '0;
         din_q      <= '0;
         dout_shr_q <= '0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         din_shr_q  <= din_shr_d;
         din_q      <= din_d;
         dout_shr_q <= dout_shr_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      din_shr_d  = din_shr_q;
      din_d      = din_q;
      dout_shr_d = dout_shr_q;
      case (state_q)
         S_IDLE: begin
            if (bus.start_i) begin
               cnt_d     = '0;
               din_shr_d = '0;
               state_d   = S_SHIFT_IN;
            end
         end
         S_SHIFT_IN: begin
            // First accepted bit migrates to the MSB after DIN_N shifts
            if (bus.di_valid_i) begin
               din_shr_d = {din_shr_q[DIN_N-2:0], bus.di_i};
               cnt_d     = cnt_q + CNT_W'(1);
               if (cnt_q == CNT_W'(DIN_N - 1)) begin
                  state_d = S_LOAD;
               end
            end
         end
         S_LOAD: begin
            din_d   = din_shr_q;
            cnt_d   = '0;
            state_d = S_SETTLE;
         end
         S_SETTLE: begin
            if (cnt_q == CNT_W'(SETTLE_N - 1)) begin
               cnt_d   = '0;
               state_d = S_CAPTURE;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         S_CAPTURE: begin
            dout_shr_d = bus.dout_i;
            cnt_d      = '0;
            state_d    = S_SHIFT_OUT;
         end
         S_SHIFT_OUT: begin
            dout_shr_d = {dout_shr_q[DOUT_N-2:0], 1'b0};
            if (cnt_q == CNT_W'(DOUT_N - 1)) begin
               cnt_d   = '0;
               state_d = S_DONE;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   assign bus.din_o      = din_q;
   assign bus.do_o       = dout_shr_q[DOUT_N-1];
   assign bus.do_valid_o = (state_q == S_SHIFT_OUT);
   assign bus.busy_o     = (state_q != S_IDLE);
   assign bus.done_o     = (state_q == S_DONE);

endmodule

`default_nettype wire

// File: tb/tb_roi_scan_ctrl.sv
// ----------------------------------------------------------------------------
// tb_roi_scan_ctrl : directed bench for roi_scan_ctrl, 8-bit buses, dout looped from din
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_roi_scan_ctrl;

   localparam int DIN_N    = 8;
   localparam int DOUT_N   = 8;
   localparam int SETTLE_N = 2;
   localparam int BUDGET   = 40;

   logic clk;
   logic rst_n;
   int   errors;
   int   checks;

   logic [7:0] obs_stream;
   int         obs_first;
   int         obs_nvalid;
   int         obs_ndone;
   int         obs_done_c;
   int         obs_busy;
   bit         obs_tmo;
   logic [7:0] obs_din1;
   logic [7:0] obs_din2;
   int         drv_busy;

   roi_scan_ctrl_if #(.DIN_N(DIN_N), .DOUT_N(DOUT_N)) bus ();

   assign bus.dout_i = bus.din_o;

   roi_scan_ctrl #(
      .DIN_N    (DIN_N),
      .DOUT_N   (DOUT_N),
      .SETTLE_N (SETTLE_N)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic cyc();
      @(negedge clk);
   endtask

   // Starts a run from IDLE and shifts v in MSB first; returns at the LOAD cycle.
   task automatic drive(input logic [7:0] v, input bit gaps);
      drv_busy = 0;
      bus.start_i = 1'b1;
      cyc();
      bus.start_i = 1'b0;
      for (int i = 7; i >= 0; i--) begin
         if (gaps) begin
            if (bus.busy_o) drv_busy++;
            bus.di_i       = ~v[i];
            bus.di_valid_i = 1'b0;
            cyc();
         end
         if (bus.busy_o) drv_busy++;
         bus.di_i       = v[i];
         bus.di_valid_i = 1'b1;
         cyc();
      end
      bus.di_valid_i = 1'b0;
      bus.di_i       = 1'b0;
   endtask

   // Observes from the LOAD cycle (c=1) until the first IDLE cycle.
   task automatic collect(input bit inject);
      int c;
      obs_stream = '0;
      obs_first  = -1;
      obs_nvalid = 0;
      obs_ndone  = 0;
      obs_done_c = -1;
      obs_busy   = 0;
      obs_din1   = 'x;
      obs_din2   = 'x;
      c = 1;
      while (c <= BUDGET) begin
         if (!bus.busy_o) break;
         obs_busy++;
         if (c == 1) obs_din1 = bus.din_o;
         if (c == 2) obs_din2 = bus.din_o;
         if (bus.do_valid_o) begin
            if (obs_nvalid == 0) obs_first = c;
            obs_stream = {obs_stream[6:0], bus.do_o};
            obs_nvalid++;
         end
         if (bus.done_o) begin
            obs_ndone++;
            obs_done_c = c;
         end
         if (inject) begin
            bus.start_i    = 1'b1;
            bus.di_valid_i = 1'b1;
            bus.di_i       = 1'b1;
         end
         cyc();
         c++;
      end
      bus.start_i    = 1'b0;
      bus.di_valid_i = 1'b0;
      bus.di_i       = 1'b0;
      obs_tmo = (c > BUDGET);
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      for (int i = 0; i < 3; i++) begin
         bus.start_i    = 1'($urandom_range(0, 1));
         bus.di_i       = 1'($urandom_range(0, 1));
         bus.di_valid_i = 1'($urandom_range(0, 1));
         cyc();
      end
      checks++; if (bus.din_o !== 8'h00) begin errors++; $display("FAIL reset_din: got %h expected 00", bus.din_o); end
      checks++; if (bus.do_o !== 1'b0) begin errors++; $display("FAIL reset_do: got %b expected 0", bus.do_o); end
      checks++; if (bus.do_valid_o !== 1'b0) begin errors++; $display("FAIL reset_do_valid: got %b expected 0", bus.do_valid_o); end
      checks++; if (bus.busy_o !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", bus.busy_o); end
      checks++; if (bus.done_o !== 1'b0) begin errors++; $display("FAIL reset_done: got %b expected 0", bus.done_o); end
      bus.start_i    = 1'b0;
      bus.di_valid_i = 1'b0;
      bus.di_i       = 1'b0;
      rst_n = 1'b1;
      cyc();
      checks++; if (bus.busy_o !== 1'b0) begin errors++; $display("FAIL reset_idle_after_release: busy got %b expected 0", bus.busy_o); end
   endtask

   task automatic test_basic();
      drive(8'hA5, 1'b0);
      collect(1'b0);
      checks++; if (obs_tmo) begin errors++; $display("FAIL basic_timeout: got busy past %0d cycles expected idle", BUDGET); end
      checks++; if (obs_din1 !== 8'h00) begin errors++; $display("FAIL basic_din_load_cycle: got %h expected 00", obs_din1); end
      checks++; if (obs_din2 !== 8'hA5) begin errors++; $display("FAIL basic_din: got %h expected a5", obs_din2); end
      checks++; if (obs_stream !== 8'hA5) begin errors++; $display("FAIL basic_stream: got %h expected a5", obs_stream); end
      checks++; if (obs_nvalid != 8) begin errors++; $display("FAIL basic_nvalid: got %0d expected 8", obs_nvalid); end
      checks++; if (obs_first != 5) begin errors++; $display("FAIL basic_first_valid: got c=%0d expected c=5", obs_first); end
      checks++; if (obs_ndone != 1 || obs_done_c != 13) begin errors++; $display("FAIL basic_done: got %0d pulses at c=%0d expected 1 at c=13", obs_ndone, obs_done_c); end
      checks++; if (drv_busy + obs_busy != 21) begin errors++; $display("FAIL basic_run_length: got %0d busy cycles expected 21", drv_busy + obs_busy); end
   endtask

   task automatic test_gaps();
      drive(8'h3C, 1'b1);
      collect(1'b0);
      checks++; if (obs_tmo) begin errors++; $display("FAIL gaps_timeout: got busy past %0d cycles expected idle", BUDGET); end
      checks++; if (obs_din1 !== 8'hA5) begin errors++; $display("FAIL gaps_din_hold: got %h expected a5", obs_din1); end
      checks++; if (obs_din2 !== 8'h3C) begin errors++; $display("FAIL gaps_din: got %h expected 3c", obs_din2); end
      checks++; if (obs_stream !== 8'h3C || obs_nvalid != 8) begin errors++; $display("FAIL gaps_stream: got %h (%0d bits) expected 3c (8 bits)", obs_stream, obs_nvalid); end
      checks++; if (drv_busy + obs_busy != 29) begin errors++; $display("FAIL gaps_run_length: got %0d busy cycles expected 29", drv_busy + obs_busy); end
   endtask

   task automatic test_ignored_inputs();
      drive(8'h96, 1'b0);
      collect(1'b1);
      checks++; if (obs_tmo) begin errors++; $display("FAIL ignored_timeout: got busy past %0d cycles expected idle", BUDGET); end
      checks++; if (obs_stream !== 8'h96 || obs_nvalid != 8) begin errors++; $display("FAIL ignored_stream: got %h (%0d bits) expected 96 (8 bits)", obs_stream, obs_nvalid); end
      checks++; if (obs_ndone != 1) begin errors++; $display("FAIL ignored_done: got %0d pulses expected 1", obs_ndone); end
      for (int i = 0; i < 3; i++) cyc();
      checks++; if (bus.busy_o !== 1'b0) begin errors++; $display("FAIL ignored_no_restart: busy got %b expected 0", bus.busy_o); end
      checks++; if (bus.din_o !== 8'h96) begin errors++; $display("FAIL ignored_din: got %h expected 96", bus.din_o); end
   endtask

   task automatic test_reset_mid_run();
      int nv;
      int nd;
      bit hit;
      nv  = 0;
      nd  = 0;
      hit = 1'b0;
      drive(8'h5A, 1'b0);
      for (int c = 0; c < BUDGET; c++) begin
         if (bus.do_valid_o) nv++;
         if (nv == 4) begin
            rst_n = 1'b0;
            hit   = 1'b1;
            break;
         end
         cyc();
      end
      checks++; if (!hit) begin errors++; $display("FAIL midreset_reach: got %0d valid cycles expected 4", nv); end
      cyc();
      checks++; if (bus.do_valid_o !== 1'b0 || bus.busy_o !== 1'b0) begin errors++; $display("FAIL midreset_abort: got do_valid=%b busy=%b expected 0 0", bus.do_valid_o, bus.busy_o); end
      checks++; if (bus.din_o !== 8'h00) begin errors++; $display("FAIL midreset_din: got %h expected 00", bus.din_o); end
      rst_n = 1'b1;
      for (int c = 0; c < 15; c++) begin
         if (bus.done_o) nd++;
         cyc();
      end
      checks++; if (nd != 0) begin errors++; $display("FAIL midreset_no_done: got %0d pulses expected 0", nd); end
      drive(8'hFF, 1'b0);
      collect(1'b0);
      checks++; if (obs_din1 !== 8'h00 || obs_din2 !== 8'hFF) begin errors++; $display("FAIL midreset_rerun_din: got %h->%h expected 00->ff", obs_din1, obs_din2); end
      checks++; if (obs_stream !== 8'hFF || obs_nvalid != 8 || obs_ndone != 1) begin errors++; $display("FAIL midreset_rerun: got %h (%0d bits, %0d done) expected ff (8 bits, 1 done)", obs_stream, obs_nvalid, obs_ndone); end
   endtask

   task automatic test_back_to_back();
      logic [7:0] s1;
      int         d1;
      drive(8'h81, 1'b0);
      collect(1'b0);
      s1 = obs_stream;
      d1 = obs_ndone;
      checks++; if (bus.busy_o !== 1'b0) begin errors++; $display("FAIL b2b_first_idle: busy got %b expected 0", bus.busy_o); end
      drive(8'h7E, 1'b0);
      collect(1'b0);
      checks++; if (s1 !== 8'h81) begin errors++; $display("FAIL b2b_stream1: got %h expected 81", s1); end
      checks++; if (obs_stream !== 8'h7E || obs_nvalid != 8) begin errors++; $display("FAIL b2b_stream2: got %h (%0d bits) expected 7e (8 bits)", obs_stream, obs_nvalid); end
      checks++; if (obs_din1 !== 8'h81 || obs_din2 !== 8'h7E) begin errors++; $display("FAIL b2b_din: got %h->%h expected 81->7e", obs_din1, obs_din2); end
      checks++; if (d1 + obs_ndone != 2) begin errors++; $display("FAIL b2b_done_count: got %0d expected 2", d1 + obs_ndone); end
      checks++; if (drv_busy + obs_busy != 21) begin errors++; $display("FAIL b2b_run_length: got %0d busy cycles expected 21", drv_busy + obs_busy); end
   endtask

   initial begin
      errors         = 0;
      checks         = 0;
      rst_n          = 1'b0;
      bus.start_i    = 1'b0;
      bus.di_i       = 1'b0;
      bus.di_valid_i = 1'b0;
      cyc();
      test_reset();
      test_basic();
      test_gaps();
      test_ignored_inputs();
      test_reset_mid_run();
      test_back_to_back();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

`default_nettype wire
